// File: rtl/skinny_sbox_sched_if.sv
// Bundle of the scheduler's controller, PRNG and S-box facing signals.
interface skinny_sbox_sched_if;
   logic        start;
   logic [63:0] st1;
   logic [63:0] st2;
   logic [63:0] st3;
   logic        busy;
   logic        done;
   logic [63:0] res1;
   logic [63:0] res2;
   logic [63:0] res3;
   logic [31:0] rnd_in;
   logic        rnd_valid;
   logic        rnd_ack;
   logic [3:0]  sb_in1;
   logic [3:0]  sb_in2;
   logic [3:0]  sb_in3;
   logic [23:0] sb_r;
   logic [7:0]  sb_rc;
   logic [3:0]  sb_out1;
   logic [3:0]  sb_out2;
   logic [3:0]  sb_out3;

   // Environment side: round controller, PRNG and the masked S-box instance.
   modport master (
      output start, st1, st2, st3, rnd_in, rnd_valid, sb_out1, sb_out2, sb_out3,
      input  busy, done, res1, res2, res3, rnd_ack, sb_in1, sb_in2, sb_in3, sb_r, sb_rc
   );

   // Scheduler side.
   modport slave (
      input  start, st1, st2, st3, rnd_in, rnd_valid, sb_out1, sb_out2, sb_out3,
      output busy, done, res1, res2, res3, rnd_ack, sb_in1, sb_in2, sb_in3, sb_r, sb_rc
   );
endinterface

// File: rtl/skinny_sbox_sched.sv
// Feeds the 16 cells of a 3-share SKINNY-64 state through one shared pipelined
// masked S-box, one cell per cycle when fresh randomness is available, and
// collects the returning shares into a 3-share result state.
module skinny_sbox_sched #(
   parameter int unsigned SBOX_LAT = 4,
   parameter int unsigned NCELL    = 16
) (
   input logic               clk,
   input logic               rst,
   skinny_sbox_sched_if.slave bus
);

   localparam int unsigned CW   = 5;           // counters span 0..NCELL
   localparam int unsigned IW   = 4;           // cell index width
   localparam int unsigned BW   = IW + 2;      // bit offset of a cell within a share
   localparam int unsigned SW   = 4 * NCELL;   // share width
   localparam int unsigned LAST = SBOX_LAT - 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t              state;
   logic                busy_q;
   logic                done_q;
   logic [CW-1:0]       issue_cnt;
   logic [CW-1:0]       ret_cnt;
   logic [SW-1:0]       sh1, sh2, sh3;
   logic [SW-1:0]       res1_q, res2_q, res3_q;
   logic [SBOX_LAT-1:0] vld_pipe;
   logic [IW-1:0]       idx_pipe [SBOX_LAT];

   logic                accept_c;
   logic                issue_c;
   logic                capture_c;
   logic                last_ret_c;
   logic [BW-1:0]       issue_base_c;
   logic [BW-1:0]       cap_base_c;

   // Control decodes shared by the FSM and datapath.
   always_comb begin
      accept_c     = (state == IDLE) && bus.start;
      issue_c      = (state == RUN) && (issue_cnt < CW'(NCELL)) && bus.rnd_valid;
      capture_c    = vld_pipe[LAST];
      last_ret_c   = capture_c && (ret_cnt == CW'(NCELL - 1));
      issue_base_c = {issue_cnt[IW-1:0], 2'b00};
      cap_base_c   = {idx_pipe[LAST], 2'b00};
   end

   // S-box operands: current cell and fresh randomness on issue, zero bubble otherwise.
   always_comb begin
      bus.sb_in1 = 4'h0;
      bus.sb_in2 = 4'h0;
      bus.sb_in3 = 4'h0;
      bus.sb_r   = 24'h0;
      bus.sb_rc  = 8'h0;
      if (issue_c) begin
         bus.sb_in1 = sh1[issue_base_c +: 4];
         bus.sb_in2 = sh2[issue_base_c +: 4];
         bus.sb_in3 = sh3[issue_base_c +: 4];
         bus.sb_r   = bus.rnd_in[23:0];
         bus.sb_rc  = bus.rnd_in[31:24];
      end
   end

   assign bus.rnd_ack = issue_c;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.res1    = res1_q;
   assign bus.res2    = res2_q;
   assign bus.res3    = res3_q;

   // Layer FSM with issue/return counters and registered busy/done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_c) begin
                  state     <= RUN;
                  busy_q    <= 1'b1;
                  issue_cnt <= '0;
                  ret_cnt   <= '0;
               end
            end
            RUN: begin
               if (issue_c) begin
                  issue_cnt <= issue_cnt + CW'(1);
               end
               if (capture_c) begin
                  ret_cnt <= ret_cnt + CW'(1);
               end
               if (last_ret_c) begin
                  state  <= FIN;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Latch the input shares on an accepted start only.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh1 <= '0;
         sh2 <= '0;
         sh3 <= '0;
      end else if (accept_c) begin
         sh1 <= bus.st1;
         sh2 <= bus.st2;
         sh3 <= bus.st3;
      end
   end

   // In-flight tracker mirroring the S-box latency; cleared on start.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         for (int i = 0; i < int'(SBOX_LAT); i++) begin
            idx_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[0] <= issue_c && !accept_c;
         idx_pipe[0] <= issue_cnt[IW-1:0];
         for (int i = 1; i < int'(SBOX_LAT); i++) begin
            vld_pipe[i] <= vld_pipe[i-1] && !accept_c;
            idx_pipe[i] <= idx_pipe[i-1];
         end
      end
   end

   // Write returning S-box shares into the addressed result cell.
   always_ff @(posedge clk) begin
      if (rst) begin
         res1_q <= '0;
         res2_q <= '0;
         res3_q <= '0;
      end else if (capture_c) begin
         res1_q[cap_base_c +: 4] <= bus.sb_out1;
         res2_q[cap_base_c +: 4] <= bus.sb_out2;
         res3_q[cap_base_c +: 4] <= bus.sb_out3;
      end
   end

endmodule
